// File: rtl/axi_outstanding_limiter_if.sv
// Default AXI payload types and the five-channel bus interface used on both sides of
// axi_outstanding_limiter (master modport drives requests, slave modport drives responses).
typedef struct packed {
   logic [3:0]  id;
   logic [31:0] addr;
   logic [7:0]  len;
} lim_aw_t;

typedef struct packed {
   logic [31:0] data;
   logic [3:0]  strb;
   logic        last;
} lim_w_t;

typedef struct packed {
   logic [3:0] id;
   logic [1:0] resp;
} lim_b_t;

typedef struct packed {
   logic [3:0]  id;
   logic [31:0] addr;
   logic [7:0]  len;
} lim_ar_t;

typedef struct packed {
   logic [3:0]  id;
   logic [31:0] data;
   logic [1:0]  resp;
   logic        last;
} lim_r_t;

interface axi_outstanding_limiter_if #(
   parameter type axi_aw_t = lim_aw_t,
   parameter type axi_w_t  = lim_w_t,
   parameter type axi_b_t  = lim_b_t,
   parameter type axi_ar_t = lim_ar_t,
   parameter type axi_r_t  = lim_r_t
) ();
   axi_aw_t aw;
   logic    awvalid;
   logic    awready;
   axi_w_t  w;
   logic    wvalid;
   logic    wready;
   axi_b_t  b;
   logic    bvalid;
   logic    bready;
   axi_ar_t ar;
   logic    arvalid;
   logic    arready;
   axi_r_t  r;
   logic    rvalid;
   logic    rready;

   modport master (
      output aw, awvalid, input awready,
      output w, wvalid, input wready,
      input b, bvalid, output bready,
      output ar, arvalid, input arready,
      input r, rvalid, output rready
   );

   modport slave (
      input aw, awvalid, output awready,
      input w, wvalid, output wready,
      output b, bvalid, input bready,
      input ar, arvalid, output arready,
      output r, rvalid, input rready
   );
endinterface

// File: rtl/axi_outstanding_limiter.sv
// Caps outstanding AXI writes (AW->B) and reads (AR->R last) with zero added latency,
// plus drain/idle control and sticky underflow error. Optional stats: AXI_LIMITER_STATS_EN.
module axi_outstanding_limiter #(
   parameter type axi_aw_t = lim_aw_t,
   parameter type axi_w_t  = lim_w_t,
   parameter type axi_b_t  = lim_b_t,
   parameter type axi_ar_t = lim_ar_t,
   parameter type axi_r_t  = lim_r_t,
   parameter int  MAX_WR   = 4,
   parameter int  MAX_RD   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   axi_outstanding_limiter_if.slave   i_axi_s,
   axi_outstanding_limiter_if.master  o_axi_m,
   input  logic                       i_drain,
   output logic                       o_idle,
`ifdef AXI_LIMITER_STATS_EN
   output logic [31:0]                o_wr_done,
   output logic [31:0]                o_rd_done,
   output logic [31:0]                o_stall_cycles,
`endif
   output logic                       o_err
);

   localparam int unsigned WR_W = $clog2(MAX_WR + 1);
   localparam int unsigned RD_W = $clog2(MAX_RD + 1);

   axi_aw_t         w_aw;
   axi_w_t          w_w;
   axi_b_t          w_b;
   axi_ar_t         w_ar;
   axi_r_t          w_r;

   logic [WR_W-1:0] r_wr_cnt;
   logic [WR_W-1:0] w_wr_nxt;
   logic [RD_W-1:0] r_rd_cnt;
   logic [RD_W-1:0] w_rd_nxt;
   logic            r_idle;
   logic            r_err;
   logic            w_wr_under;
   logic            w_rd_under;
   logic            w_aw_allow;
   logic            w_ar_allow;
   logic            w_aw_hs;
   logic            w_b_hs;
   logic            w_ar_hs;
   logic            w_r_done;

   // Gating depends only on registered counts and i_drain, so no ready->valid loop exists.
   assign w_aw_allow = (r_wr_cnt < WR_W'(MAX_WR)) & ~i_drain;
   assign w_ar_allow = (r_rd_cnt < RD_W'(MAX_RD)) & ~i_drain;

   assign w_aw                = i_axi_s.aw;
   assign o_axi_m.aw          = w_aw;
   assign o_axi_m.awvalid     = i_axi_s.awvalid & w_aw_allow;
   assign i_axi_s.awready     = o_axi_m.awready & w_aw_allow;

   assign w_w                 = i_axi_s.w;
   assign o_axi_m.w           = w_w;
   assign o_axi_m.wvalid      = i_axi_s.wvalid;
   assign i_axi_s.wready      = o_axi_m.wready;

   assign w_b                 = o_axi_m.b;
   assign i_axi_s.b           = w_b;
   assign i_axi_s.bvalid      = o_axi_m.bvalid;
   assign o_axi_m.bready      = i_axi_s.bready;

   assign w_ar                = i_axi_s.ar;
   assign o_axi_m.ar          = w_ar;
   assign o_axi_m.arvalid     = i_axi_s.arvalid & w_ar_allow;
   assign i_axi_s.arready     = o_axi_m.arready & w_ar_allow;

   assign w_r                 = o_axi_m.r;
   assign i_axi_s.r           = w_r;
   assign i_axi_s.rvalid      = o_axi_m.rvalid;
   assign o_axi_m.rready      = i_axi_s.rready;

   assign w_aw_hs  = i_axi_s.awvalid & o_axi_m.awready & w_aw_allow;
   assign w_b_hs   = o_axi_m.bvalid & i_axi_s.bready;
   assign w_ar_hs  = i_axi_s.arvalid & o_axi_m.arready & w_ar_allow;
   assign w_r_done = o_axi_m.rvalid & i_axi_s.rready & w_r.last;

   // Write count: issue and completion in the same cycle cancel; completion at zero flags underflow.
   always_comb begin
      w_wr_nxt   = r_wr_cnt;
      w_wr_under = 1'b0;
      if (w_aw_hs && !w_b_hs) begin
         w_wr_nxt = r_wr_cnt + WR_W'(1);
      end else if (w_b_hs && !w_aw_hs) begin
         if (r_wr_cnt == '0) begin
            w_wr_under = 1'b1;
         end else begin
            w_wr_nxt = r_wr_cnt - WR_W'(1);
         end
      end
   end

   always_comb begin
      w_rd_nxt   = r_rd_cnt;
      w_rd_under = 1'b0;
      if (w_ar_hs && !w_r_done) begin
         w_rd_nxt = r_rd_cnt + RD_W'(1);
      end else if (w_r_done && !w_ar_hs) begin
         if (r_rd_cnt == '0) begin
            w_rd_under = 1'b1;
         end else begin
            w_rd_nxt = r_rd_cnt - RD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
         r_idle   <= 1'b1;
         r_err    <= 1'b0;
      end else begin
         r_wr_cnt <= w_wr_nxt;
         r_rd_cnt <= w_rd_nxt;
         r_idle   <= (w_wr_nxt == '0) && (w_rd_nxt == '0);
         r_err    <= r_err | w_wr_under | w_rd_under;
      end
   end

   assign o_idle = r_idle;
   assign o_err  = r_err;

`ifdef AXI_LIMITER_STATS_EN
   logic [31:0] r_wr_done;
   logic [31:0] r_rd_done;
   logic [31:0] r_stall;
   logic        w_stall;

   // A stall cycle is any cycle where the CPU offers AW or AR but the gate is closed.
   assign w_stall = (i_axi_s.awvalid & ~w_aw_allow) | (i_axi_s.arvalid & ~w_ar_allow);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_done <= '0;
         r_rd_done <= '0;
         r_stall   <= '0;
      end else begin
         r_wr_done <= r_wr_done + 32'(w_b_hs);
         r_rd_done <= r_rd_done + 32'(w_r_done);
         if (w_stall && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
         end
      end
   end

   assign o_wr_done      = r_wr_done;
   assign o_rd_done      = r_rd_done;
   assign o_stall_cycles = r_stall;
`endif

endmodule
